mem_arbiter: RTL and testbench

Sequential memory-side responder for the cache request interface: accepts word requests from one icache and one dcache, arbitrates for the single RAM port, and returns data with the `iwait`/`dwait` handshake. Sits between the caches and RAM. Holds the grant across a dcache two-word block so write-back and fill beats are never interleaved with instruction fetches. Bounded icache starvation and per-requester beat counters for performance checks.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the cache-to-RAM arbiter
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache/dcache request ports and the single RAM port
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Caches and RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates icache/dcache word requests onto one RAM port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus,
    output word_t         ibeats,
    output word_t         dbeats
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state, next_state;
    logic          lock;
    logic [SW-1:0] starve;

    logic d_req;
    logic i_done;
    logic d_done;

    assign d_req  = bus.dREN | bus.dWEN;
    assign i_done = (state == IGNT) && bus.iREN && (bus.ramstate == ACCESS);
    assign d_done = (state == DGNT) && d_req && (bus.ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            lock   <= 1'b0;
            starve <= '0;
            ibeats <= '0;
            dbeats <= '0;
        end else begin
            state <= next_state;

            // First word of a block arms the lock; second word or withdrawal releases it
            if (d_done)
                lock <= ~bus.daddr[2] & ~lock;
            else if ((state == DGNT) && !d_req)
                lock <= 1'b0;

            if (!bus.iREN)
                starve <= '0;
            else if ((state == IDLE) && (next_state == IGNT))
                starve <= '0;
            else if ((state == IDLE) && (next_state == DGNT) && (starve != STARVE_MAX))
                starve <= starve + 1'b1;

            ibeats <= ibeats + 32'(i_done);
            dbeats <= dbeats + 32'(d_done);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.iREN && ((starve == STARVE_MAX) || !d_req))
                    next_state = IGNT;
                else if (d_req)
                    next_state = DGNT;
            end
            IGNT: begin
                if (!bus.iREN || i_done)
                    next_state = IDLE;
            end
            DGNT: begin
                if (!d_req)
                    next_state = IDLE;
                else if (d_done && (bus.daddr[2] || lock))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                if (i_done) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (d_done) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable RAM model
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic  CLK;
    logic  nRST;
    word_t ibeats, dbeats;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus),
        .ibeats (ibeats),
        .dbeats (dbeats)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // RAM model: ACCESS after ram_lat cycles of asserted enables
    int   ram_lat;
    int   busy_cnt;
    logic ram_en;

    assign ram_en      = bus.ramREN | bus.ramWEN;
    assign bus.ramload = (bus.ramaddr == 32'h40) ? 32'hDEAD_BEEF : (bus.ramaddr ^ 32'hA5A5_0000);

    always_comb begin
        bus.ramstate = FREE;
        if (ram_en)
            bus.ramstate = (busy_cnt >= ram_lat - 1) ? ACCESS : BUSY;
    end

    always @(posedge CLK) begin
        if (!ram_en || bus.ramstate == ACCESS)
            busy_cnt <= 0;
        else
            busy_cnt <= busy_cnt + 1;
    end

    typedef struct {
        bit    is_d;
        word_t load;
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    task automatic push(input bit d, input word_t ld, input logic ren, input logic wen,
                        input word_t a, input word_t st);
        exp_t e;
        e.is_d = d; e.load = ld; e.ren = ren; e.wen = wen; e.addr = a; e.store = st;
        sb_q.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (nRST && (!bus.iwait || !bus.dwait)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: iwait=%0b dwait=%0b addr=0x%08h", bus.iwait, bus.dwait, bus.ramaddr);
            end else begin
                e = sb_q.pop_front();
                check("beat_owner_is_d", 32'(!bus.dwait), 32'(e.is_d));
                check("beat_ramREN",   32'(bus.ramREN), 32'(e.ren));
                check("beat_ramWEN",   32'(bus.ramWEN), 32'(e.wen));
                check("beat_ramaddr",  bus.ramaddr,  e.addr);
                check("beat_ramstore", bus.ramstore, e.store);
                if (e.is_d) begin
                    check("beat_dload",        bus.dload, e.load);
                    check("beat_nonowner_iwait", 32'(bus.iwait), 32'd1);
                    check("beat_nonowner_iload", bus.iload, 32'd0);
                end else begin
                    check("beat_iload",        bus.iload, e.load);
                    check("beat_nonowner_dwait", 32'(bus.dwait), 32'd1);
                    check("beat_nonowner_dload", bus.dload, 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iwait"},    32'(bus.iwait),  32'd1);
        check({tag, "_dwait"},    32'(bus.dwait),  32'd1);
        check({tag, "_ramREN"},   32'(bus.ramREN), 32'd0);
        check({tag, "_ramWEN"},   32'(bus.ramWEN), 32'd0);
        check({tag, "_ramaddr"},  bus.ramaddr,  32'd0);
        check({tag, "_ramstore"}, bus.ramstore, 32'd0);
        check({tag, "_iload"},    bus.iload,    32'd0);
        check({tag, "_dload"},    bus.dload,    32'd0);
        check({tag, "_ibeats"},   ibeats,       32'd0);
        check({tag, "_dbeats"},   dbeats,       32'd0);
        check({tag, "_state"},    32'(dut.state), 32'(IDLE));
        check({tag, "_lock"},     32'(dut.lock),  32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},  32'(dut.state), 32'(IDLE));
        check({tag, "_ramREN"}, 32'(bus.ramREN), 32'd0);
        check({tag, "_iwait"},  32'(bus.iwait),  32'd1);
        check({tag, "_dwait"},  32'(bus.dwait),  32'd1);
    endtask

    initial begin
        nRST = 1'b0;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        ram_lat = 1;

        repeat (2) smp();
        check_reset_outputs("por");
        tick();
        nRST = 1'b1;
        tick();

        // icache alone, RAM latency 2
        ram_lat = 2;
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        push(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h40, 32'h0);
        smp();
        check("ic_c0_ramREN", 32'(bus.ramREN), 32'd0);
        tick();
        smp();
        check("ic_c1_ramREN", 32'(bus.ramREN), 32'd1);
        check("ic_c1_iwait",  32'(bus.iwait),  32'd1);
        tick();
        smp();
        check("ic_c2_iwait",  32'(bus.iwait),  32'd0);
        tick();
        bus.iREN = 1'b0;
        smp();
        check("ic_ibeats", ibeats, 32'd1);
        check_idle("ic_after");

        // dcache write-back block, latency 1
        ram_lat = 1;
        tick();
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h11;
        push(1'b1, 32'hA5A5_0100, 1'b0, 1'b1, 32'h100, 32'h11);
        tick();
        smp();
        check("wb_c1_dwait", 32'(bus.dwait), 32'd0);
        tick();
        bus.daddr = 32'h104; bus.dstore = 32'h22;
        push(1'b1, 32'hA5A5_0104, 1'b0, 1'b1, 32'h104, 32'h22);
        smp();
        check("wb_c2_dwait_no_bubble", 32'(bus.dwait), 32'd0);
        check("wb_c2_lock", 32'(dut.lock), 32'd1);
        tick();
        bus.dWEN = 1'b0;
        smp();
        check("wb_dbeats", dbeats, 32'd2);
        check("wb_lock_clr", 32'(dut.lock), 32'd0);
        check_idle("wb_after");

        // contention: dcache block first, then IDLE, then icache
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dREN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h0;
        push(1'b1, 32'hA5A5_0200, 1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        tick();
        bus.daddr = 32'h204;
        push(1'b1, 32'hA5A5_0204, 1'b1, 1'b0, 32'h204, 32'h0);
        tick();
        bus.dREN = 1'b0;
        push(1'b0, 32'hA5A5_0080, 1'b1, 1'b0, 32'h80, 32'h0);
        smp();
        check_idle("ct_bubble");
        tick();
        smp();
        check("ct_igrant_state", 32'(dut.state), 32'(IGNT));
        check("ct_igrant_dwait", 32'(bus.dwait), 32'd1);
        tick();
        bus.iREN = 1'b0;

        // starvation with STARVE_LIMIT=2: third arbitration goes to icache
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dREN = 1'b1; bus.daddr = 32'h300;
        push(1'b1, 32'hA5A5_0300, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        tick();
        bus.daddr = 32'h304;
        push(1'b1, 32'hA5A5_0304, 1'b1, 1'b0, 32'h304, 32'h0);
        tick();
        bus.daddr = 32'h308;
        push(1'b1, 32'hA5A5_0308, 1'b1, 1'b0, 32'h308, 32'h0);
        smp();
        check_idle("sv_arb2");
        tick();
        tick();
        bus.daddr = 32'h30C;
        push(1'b1, 32'hA5A5_030C, 1'b1, 1'b0, 32'h30C, 32'h0);
        tick();
        bus.daddr = 32'h310;
        push(1'b0, 32'hA5A5_0080, 1'b1, 1'b0, 32'h80, 32'h0);
        smp();
        check_idle("sv_arb3");
        tick();
        smp();
        check("sv_icache_wins", 32'(dut.state), 32'(IGNT));
        tick();
        bus.iREN = 1'b0; bus.dREN = 1'b0;

        // withdrawal while locked
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dREN = 1'b1; bus.daddr = 32'h400;
        push(1'b1, 32'hA5A5_0400, 1'b1, 1'b0, 32'h400, 32'h0);
        tick();
        tick();
        bus.dREN = 1'b0;
        smp();
        check("wd_drop_ramREN", 32'(bus.ramREN), 32'd0);
        check("wd_drop_dwait",  32'(bus.dwait),  32'd1);
        tick();
        push(1'b0, 32'hA5A5_0080, 1'b1, 1'b0, 32'h80, 32'h0);
        smp();
        check_idle("wd_idle");
        check("wd_lock_clr", 32'(dut.lock), 32'd0);
        tick();
        smp();
        check("wd_igrant", 32'(dut.state), 32'(IGNT));
        tick();
        bus.iREN = 1'b0;
        smp();
        check("total_ibeats", ibeats, 32'd4);
        check("total_dbeats", dbeats, 32'd9);

        // reset mid-DGNT with RAM busy
        ram_lat = 3;
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h500;
        tick();
        smp();
        check("rst_pre_ramREN", 32'(bus.ramREN), 32'd1);
        check("rst_pre_dwait",  32'(bus.dwait),  32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.dREN = 1'b0;
        tick();
        smp();
        check_reset_outputs("midrst_hold");
        tick();
        nRST = 1'b1;
        tick();
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
